// File: rtl/spc7110_alu.sv
// SPC7110 arithmetic unit ($4820-$482F): operand/result/mode registers and a 16x16 multiply / 32/16 divide engine.
// Latency: multiply 16/STEPS_PER_CLK cycles, divide 32/STEPS_PER_CLK cycles; with SPC7110_ALU_FAST_EN defined, 1 cycle.
// No backpressure: the SNES polls busy ($482F bit7); a start strobe while busy abandons the running op and restarts.
module spc7110_alu #(
  parameter int STEPS_PER_CLK = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       alu_enable,
  input  logic       reg_we,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_data_in,
  output logic [7:0] reg_data_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // Host-visible registers
  logic [31:0] dvd;
  logic [15:0] mlr;
  logic [15:0] dvs;
  logic        mode;
  logic [31:0] res;
  logic [15:0] rem;

  // Register values including the byte being written this cycle
  logic [31:0] dvd_nx;
  logic [15:0] mlr_nx;
  logic [15:0] dvs_nx;
  logic        mode_nx;
  logic        wr;
  logic        start_mul;
  logic        start_div;

  // Operand magnitudes taken from the post-write register values
  logic [15:0] mag_a;
  logic [15:0] mag_b;
  logic [15:0] mag_d;
  logic [31:0] mag_n;

  // Working state of the running operation
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc;     // product accumulator, or dividend/quotient shift register
  logic [31:0] mcand;   // multiplicand, shifted left one bit per step
  logic [15:0] mplier;  // multiplier, shifted right one bit per step
  logic [15:0] wdvs;    // divisor magnitude
  logic [16:0] prem;    // partial remainder (one spare bit for the shift-in)
  logic        neg_q;
  logic        neg_r;
  logic        dz;
  logic [15:0] dz_rem;

  logic [31:0] acc_n;
  logic [31:0] mcand_n;
  logic [15:0] mplier_n;
  logic [16:0] prem_n;
  logic        last;
  logic [31:0] res_fix;
  logic [15:0] rem_fix;

  assign wr        = alu_enable && reg_we;
  assign start_mul = wr && (reg_addr == 4'h5);
  assign start_div = wr && (reg_addr == 4'h7);

  // Merge the incoming write byte so a start strobe latches its own byte too
  always_comb begin
    dvd_nx  = dvd;
    mlr_nx  = mlr;
    dvs_nx  = dvs;
    mode_nx = mode;
    if (wr) begin
      case (reg_addr)
        4'h0: dvd_nx[7:0]   = reg_data_in;
        4'h1: dvd_nx[15:8]  = reg_data_in;
        4'h2: dvd_nx[23:16] = reg_data_in;
        4'h3: dvd_nx[31:24] = reg_data_in;
        4'h4: mlr_nx[7:0]   = reg_data_in;
        4'h5: mlr_nx[15:8]  = reg_data_in;
        4'h6: dvs_nx[7:0]   = reg_data_in;
        4'h7: dvs_nx[15:8]  = reg_data_in;
        4'hE: mode_nx       = reg_data_in[0];
        default: ;
      endcase
    end
  end

  assign mag_a = (mode_nx && dvd_nx[15]) ? -dvd_nx[15:0] : dvd_nx[15:0];
  assign mag_b = (mode_nx && mlr_nx[15]) ? -mlr_nx : mlr_nx;
  assign mag_d = (mode_nx && dvs_nx[15]) ? -dvs_nx : dvs_nx;
  assign mag_n = (mode_nx && dvd_nx[31]) ? -dvd_nx : dvd_nx;

`ifdef SPC7110_ALU_FAST_EN
  // Whole operation in one cycle on the latched magnitudes
  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    prem_n   = prem;
    last     = 1'b1;
    if (state == MUL) begin
      acc_n = mcand * {16'h0000, mplier};
    end else if (state == DIV && wdvs != 16'h0000) begin
      acc_n  = acc / {16'h0000, wdvs};
      prem_n = {1'b0, 16'(acc % {16'h0000, wdvs})};
    end
  end
`else
  localparam logic [4:0] MUL_LAST = 5'(16 / STEPS_PER_CLK - 1);
  localparam logic [4:0] DIV_LAST = 5'(32 / STEPS_PER_CLK - 1);

  // STEPS_PER_CLK shift-add or restoring-divide steps per cycle
  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    prem_n   = prem;
    last     = (state == MUL) ? (cnt == MUL_LAST) : (cnt == DIV_LAST);
    for (int i = 0; i < STEPS_PER_CLK; i++) begin
      if (state == MUL) begin
        if (mplier_n[0]) acc_n = acc_n + mcand_n;
        mcand_n  = {mcand_n[30:0], 1'b0};
        mplier_n = {1'b0, mplier_n[15:1]};
      end else if (state == DIV) begin
        prem_n = {prem_n[15:0], acc_n[31]};
        acc_n  = {acc_n[30:0], 1'b0};
        if (prem_n >= {1'b0, wdvs}) begin
          prem_n   = prem_n - {1'b0, wdvs};
          acc_n[0] = 1'b1;
        end
      end
    end
  end
`endif

  // Sign fixup and divide-by-zero override applied on the completion edge
  always_comb begin
    res_fix = res;
    rem_fix = rem;
    if (state == MUL) begin
      res_fix = neg_q ? -acc_n : acc_n;
    end else if (dz) begin
      res_fix = 32'h0000_0000;
      rem_fix = dz_rem;
    end else begin
      res_fix = neg_q ? -acc_n : acc_n;
      rem_fix = neg_r ? -prem_n[15:0] : prem_n[15:0];
    end
  end

  // Host register file; writes to read-only offsets fall through the merge above
  always_ff @(posedge CLK) begin
    if (RST) begin
      dvd  <= '0;
      mlr  <= '0;
      dvs  <= '0;
      mode <= 1'b0;
    end else begin
      dvd  <= dvd_nx;
      mlr  <= mlr_nx;
      dvs  <= dvs_nx;
      mode <= mode_nx;
    end
  end

  // Operation FSM: start/restart latches operands, completion writes results and drops busy
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      rem    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      wdvs   <= '0;
      prem   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      dz_rem <= '0;
    end else if (start_mul) begin
      state  <= MUL;
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {16'h0000, mag_a};
      mplier <= mag_b;
      neg_q  <= mode_nx && (dvd_nx[15] ^ mlr_nx[15]);
    end else if (start_div) begin
      state  <= DIV;
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= mag_n;
      prem   <= '0;
      wdvs   <= mag_d;
      neg_q  <= mode_nx && (dvd_nx[31] ^ dvs_nx[15]);
      neg_r  <= mode_nx && dvd_nx[31];
      dz     <= (dvs_nx == 16'h0000);
      dz_rem <= dvd_nx[15:0];
    end else if (state != IDLE) begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      prem   <= prem_n;
      cnt    <= cnt + 5'd1;
      if (last) begin
        state <= IDLE;
        busy  <= 1'b0;
        res   <= res_fix;
        rem   <= rem_fix;
      end
    end
  end

  // Combinational read mux for the SNES data bus
  always_comb begin
    reg_data_out = 8'h00;
    case (reg_addr)
      4'h0: reg_data_out = dvd[7:0];
      4'h1: reg_data_out = dvd[15:8];
      4'h2: reg_data_out = dvd[23:16];
      4'h3: reg_data_out = dvd[31:24];
      4'h4: reg_data_out = mlr[7:0];
      4'h5: reg_data_out = mlr[15:8];
      4'h6: reg_data_out = dvs[7:0];
      4'h7: reg_data_out = dvs[15:8];
      4'h8: reg_data_out = res[7:0];
      4'h9: reg_data_out = res[15:8];
      4'hA: reg_data_out = res[23:16];
      4'hB: reg_data_out = res[31:24];
      4'hC: reg_data_out = rem[7:0];
      4'hD: reg_data_out = rem[15:8];
      4'hE: reg_data_out = {7'b0000000, mode};
      4'hF: reg_data_out = {busy, 7'b0000000};
    endcase
  end

endmodule

// File: tb/tb_spc7110_alu.sv
// Bench for spc7110_alu: directed cases plus random multiply/divide against an arithmetic reference.
// Inputs change on the falling edge; outputs are sampled at or just after the falling edge.
// Every wait on busy is bounded; an expired bound is counted as a mismatch.
module tb_spc7110_alu;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       alu_enable = 1'b0;
  logic       reg_we = 1'b0;
  logic [3:0] reg_addr = 4'h0;
  logic [7:0] reg_data_in = 8'h00;
  logic [7:0] reg_data_out;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  // Reference copy of the visible register file
  logic [31:0] m_dvd;
  logic [15:0] m_mlr;
  logic [15:0] m_dvs;
  logic        m_mode;
  logic [31:0] m_res;
  logic [15:0] m_rem;

`ifdef SPC7110_ALU_FAST_EN
  localparam int MUL_CYC = 1;
  localparam int DIV_CYC = 1;
  localparam int MID     = 0;
`else
  localparam int MUL_CYC = 16;
  localparam int DIV_CYC = 32;
  localparam int MID     = 10;
`endif

  spc7110_alu #(.STEPS_PER_CLK(1)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .alu_enable  (alu_enable),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_data_in (reg_data_in),
    .reg_data_out(reg_data_out),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_dvd = '0; m_mlr = '0; m_dvs = '0; m_mode = 1'b0; m_res = '0; m_rem = '0;
  endtask

  // One write cycle; called and returns just after a falling edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic en);
    alu_enable = en; reg_we = 1'b1; reg_addr = a; reg_data_in = d;
    if (en) begin
      case (a)
        4'h0, 4'h1, 4'h2, 4'h3: m_dvd[8*int'(a) +: 8] = d;
        4'h4: m_mlr[7:0]  = d;
        4'h5: m_mlr[15:8] = d;
        4'h6: m_dvs[7:0]  = d;
        4'h7: m_dvs[15:8] = d;
        4'hE: m_mode      = d[0];
        default: ;
      endcase
    end
    @(negedge CLK);
    alu_enable = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    reg_addr = a; #1; d = reg_data_out;
  endtask

  task automatic rd32(input logic [3:0] a, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      rd(a + 4'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic rd16(input logic [3:0] a, output logic [15:0] v);
    logic [7:0] b;
    rd(a, b); v[7:0] = b;
    rd(a + 4'h1, b); v[15:8] = b;
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    case (a)
      0, 1, 2, 3:     return m_dvd[8*a +: 8];
      4, 5:           return m_mlr[8*(a-4) +: 8];
      6, 7:           return m_dvs[8*(a-6) +: 8];
      8, 9, 10, 11:   return m_res[8*(a-8) +: 8];
      12, 13:         return m_rem[8*(a-12) +: 8];
      14:             return {7'b0000000, m_mode};
      default:        return 8'h00;  // status while idle
    endcase
  endfunction

  // Full register sweep; only used while idle
  task automatic check_regs(input string tag);
    logic [7:0] b;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), b);
      chk($sformatf("%s reg%0h", tag, a), {24'h0, b}, {24'h0, exp_byte(a)});
    end
    @(negedge CLK);
  endtask

  // Reference arithmetic straight from the operand values
  function automatic logic [31:0] ref_mul();
    longint p;
    if (m_mode) p = longint'($signed(m_dvd[15:0])) * longint'($signed(m_mlr));
    else        p = longint'(m_dvd[15:0]) * longint'(m_mlr);
    return p[31:0];
  endfunction

  task automatic ref_div(output logic [31:0] q, output logic [15:0] r);
    longint n, d, qq, rr;
    if (m_dvs == 16'h0000) begin
      q = 32'h0; r = m_dvd[15:0];
    end else begin
      if (m_mode) begin n = longint'($signed(m_dvd)); d = longint'($signed(m_dvs)); end
      else begin n = longint'(m_dvd); d = longint'(m_dvs); end
      qq = n / d; rr = n % d;
      q = qq[31:0]; r = rr[15:0];
    end
  endtask

  task automatic wait_busy(input int exp_cyc, input string tag);
    int n;
    logic [31:0] v;
    n = 0;
    if (busy === 1'b1) begin
      rd32(4'h8, v);
      chk({tag, " result held while busy"}, v, m_res);
    end
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic do_op(input bit is_div, input logic [31:0] n, input logic [15:0] d,
                       input bit mode, input string tag);
    logic [31:0] er, v;
    logic [15:0] erem, v16;
    wr(4'hE, {7'b0000000, mode}, 1'b1);
    for (int i = 0; i < 4; i++) wr(4'(i), n[8*i +: 8], 1'b1);
    if (is_div) begin
      wr(4'h6, d[7:0], 1'b1);
      wr(4'h7, d[15:8], 1'b1);
      ref_div(er, erem);
    end else begin
      wr(4'h4, d[7:0], 1'b1);
      wr(4'h5, d[15:8], 1'b1);
      er = ref_mul();
      erem = m_rem;
    end
    wait_busy(is_div ? DIV_CYC : MUL_CYC, tag);
    m_res = er; m_rem = erem;
    rd32(4'h8, v);
    chk({tag, " result"}, v, er);
    rd16(4'hC, v16);
    chk({tag, " remainder"}, {16'h0, v16}, {16'h0, erem});
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] v, er;
    logic [15:0] v16, erem;
    logic [7:0]  b;
    model_clear();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("busy after reset", {31'h0, busy}, 32'h0);
    check_regs("reset");

    // Directed arithmetic cases with literal expectations as well
    do_op(1'b1, 32'h0001_0000, 16'h0003, 1'b0, "udiv");
    rd32(4'h8, v); chk("udiv quotient literal", v, 32'h0000_5555);
    rd16(4'hC, v16); chk("udiv remainder literal", {16'h0, v16}, 32'h0000_0001);
    @(negedge CLK);
    do_op(1'b0, 32'h0000_1234, 16'h5678, 1'b0, "umul");
    rd32(4'h8, v); chk("umul product literal", v, 32'h0626_0060);
    rd16(4'hC, v16); chk("umul remainder kept", {16'h0, v16}, 32'h0000_0001);
    @(negedge CLK);
    do_op(1'b0, 32'h0000_FFFE, 16'h0003, 1'b1, "smul");
    rd32(4'h8, v); chk("smul product literal", v, 32'hFFFF_FFFA);
    @(negedge CLK);
    do_op(1'b1, 32'hFFFF_FFF9, 16'h0002, 1'b1, "sdiv");
    rd32(4'h8, v); chk("sdiv quotient literal", v, 32'hFFFF_FFFD);
    rd16(4'hC, v16); chk("sdiv remainder literal", {16'h0, v16}, 32'h0000_FFFF);
    @(negedge CLK);
    do_op(1'b1, 32'h1234_5678, 16'h0000, 1'b0, "div0");
    rd32(4'h8, v); chk("div0 quotient literal", v, 32'h0000_0000);
    rd16(4'hC, v16); chk("div0 remainder literal", {16'h0, v16}, 32'h0000_5678);
    @(negedge CLK);
    do_op(1'b1, 32'h8765_4321, 16'h0000, 1'b1, "div0 signed");
    do_op(1'b1, 32'h8000_0000, 16'hFFFF, 1'b1, "minint div");
    rd32(4'h8, v); chk("minint quotient literal", v, 32'h8000_0000);
    @(negedge CLK);
    do_op(1'b0, 32'h0000_8000, 16'h8000, 1'b1, "smul minmin");
    check_regs("after directed");

    // Read-only offsets, disabled window and mode bit masking
    wr(4'h8, 8'hFF, 1'b1);
    wr(4'hC, 8'hFF, 1'b1);
    wr(4'hF, 8'hFF, 1'b1);
    wr(4'h0, 8'h77, 1'b0);
    wr(4'h5, 8'h77, 1'b0);
    chk("disabled start ignored", {31'h0, busy}, 32'h0);
    wr(4'hE, 8'hFF, 1'b1);
    check_regs("ro writes");
    wr(4'hE, 8'hFE, 1'b1);
    check_regs("mode cleared");

    // Operand writes while busy change only the visible registers
    wr(4'h0, 8'h21, 1'b1); wr(4'h1, 8'h43, 1'b1); wr(4'h4, 8'h65, 1'b1);
    wr(4'h5, 8'h07, 1'b1);
    er = ref_mul(); erem = m_rem;
    wr(4'h0, 8'hAA, 1'b1);
    wr(4'h1, 8'h55, 1'b1);
    rd16(4'h0, v16);
    chk("visible operand while busy", {16'h0, v16}, 32'h0000_55AA);
    wait_busy((MUL_CYC > 2) ? MUL_CYC - 2 : 0, "busy write");
    m_res = er; m_rem = erem;
    @(negedge CLK);
    check_regs("busy write");

    // Restart: divide interrupted by a multiply start strobe
    wr(4'h6, 8'h03, 1'b1); wr(4'h7, 8'h00, 1'b1);
    repeat (MID) @(negedge CLK);
    chk("div running before restart", {31'h0, busy}, (MID > 0) ? 32'h1 : 32'h1);
    wr(4'h5, 8'h12, 1'b1);
    er = ref_mul(); erem = m_rem;
    wait_busy(MUL_CYC, "restart");
    m_res = er; m_rem = erem;
    @(negedge CLK);
    check_regs("restart");

    // Random operations against the reference
    for (int k = 0; k < 24; k++) begin
      logic [15:0] dd;
      dd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      do_op(1'($urandom), $urandom, dd, 1'($urandom), $sformatf("rand%0d", k));
    end
    check_regs("after random");

    // Reset mid-multiply together with a start strobe: reset wins
    wr(4'h5, 8'h33, 1'b1);
    repeat (MID / 2) @(negedge CLK);
    RST = 1'b1; alu_enable = 1'b1; reg_we = 1'b1; reg_addr = 4'h5; reg_data_in = 8'h44;
    @(negedge CLK);
    RST = 1'b0; alu_enable = 1'b0; reg_we = 1'b0;
    model_clear();
    rd(4'hF, b);
    chk("busy after mid reset", {24'h0, b}, 32'h0);
    check_regs("mid reset");
    repeat (40) @(negedge CLK);
    chk("no late completion", {31'h0, busy}, 32'h0);
    check_regs("post reset idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
